// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV32M multiply/divide sequencer; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic [XLEN-1:0] RESULT,
    output logic            DONE,
    output logic            BUSY,
    output logic            STALL
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;        // FUNC3[1:0]; FUNC3[2] is implied by the state
    logic              neg_q, neg_d;        // negate the magnitude result at the end
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   opb_q, opb_d;        // multiplicand magnitude, or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;        // {hi, lo}: product, or {remainder, quotient}
    logic [XLEN-1:0]   result_q, result_d;

    logic              op1_signed, op2_signed;
    logic              op1_neg, op2_neg;
    logic [XLEN-1:0]   op1_mag, op2_mag;
    logic [XLEN:0]     div_shift, div_diff;

    // Signedness per op: MULH both, MULHSU rs1 only, DIV/REM both, the rest unsigned
    assign op1_signed = FUNC3[2] ? ~FUNC3[0] : (FUNC3[1] ^ FUNC3[0]);
    assign op2_signed = FUNC3[2] ? ~FUNC3[0] : (FUNC3[1:0] == 2'b01);
    assign op1_neg    = op1_signed & OPERAND1[XLEN-1];
    assign op2_neg    = op2_signed & OPERAND2[XLEN-1];
    assign op1_mag    = op1_neg ? -OPERAND1 : OPERAND1;
    assign op2_mag    = op2_neg ? -OPERAND2 : OPERAND2;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] mul_full;
    assign mul_full = {{XLEN{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
`else
    logic [XLEN:0] mul_sum;
    // Shift-add: add the multiplicand into the high half when the current multiplier bit is set
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
`endif

    // Restoring step: shift the next dividend bit into the remainder and trial-subtract
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] prod,
                                                  input logic neg, input logic low);
        logic [2*XLEN-1:0] p;
        p = neg ? -prod : prod;
        return low ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] div_pick(input logic [2*XLEN-1:0] qr,
                                                  input logic neg, input logic rem);
        logic [XLEN-1:0] r;
        r = rem ? qr[2*XLEN-1:XLEN] : qr[XLEN-1:0];
        return neg ? -r : r;
    endfunction

    // State register and datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Next-state logic, operand capture, iteration and result formation
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (START && !FLUSH) begin
                    sel_d = FUNC3[1:0];
                    cnt_d = '0;
                    neg_d = (FUNC3[2] && FUNC3[1]) ? op1_neg : (op1_neg ^ op2_neg);
                    if (!FUNC3[2]) begin
                        opb_d   = op1_mag;
                        acc_d   = {{XLEN{1'b0}}, op2_mag};
                        state_d = S_MUL;
                    end else if (OPERAND2 == '0) begin
                        result_d = FUNC3[1] ? OPERAND1 : '1;
                        state_d  = S_DONE;
                    end else if (!FUNC3[0] && OPERAND1 == INT_MIN && OPERAND2 == '1) begin
                        result_d = FUNC3[1] ? '0 : INT_MIN;
                        state_d  = S_DONE;
                    end else begin
                        opb_d   = op2_mag;
                        acc_d   = {{XLEN{1'b0}}, op1_mag};
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                acc_d    = mul_full;
                result_d = mul_pick(mul_full, neg_q, sel_q == 2'b00);
                state_d  = S_DONE;
`else
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = mul_pick(acc_d, neg_q, sel_q == 2'b00);
                    state_d  = S_DONE;
                end
`endif
            end
            S_DIV: begin
                if (!div_diff[XLEN]) begin
                    acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = div_pick(acc_d, neg_q, sel_q[1]);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect kills whatever is in flight and keeps the last delivered result
        if (FLUSH) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    assign RESULT = result_q;
    assign DONE   = (state_q == S_DONE);
    assign BUSY   = (state_q == S_MUL) || (state_q == S_DIV);
    assign STALL  = ((state_q == S_IDLE) && START && !FLUSH) || BUSY;

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; verification is at the default only.
REQ-002 SHALL have port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: START  input  1  RV32M instruction (OPCODE 0110011, FUNC7 0000001) valid in EX.
REQ-005 SHALL have port: FUNC3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports: OPERAND1 and OPERAND2  input  XLEN  rs1 and rs2 values (dividend/divisor for divides).
REQ-007 SHALL have port: FLUSH  input  1  kill the in-flight operation (branch/jump redirect).
REQ-008 SHALL have port: RESULT  output  XLEN  registered result, valid while DONE=1.
REQ-009 SHALL have port: DONE  output  1  one-cycle pulse marking RESULT valid.
REQ-010 SHALL have port: BUSY  output  1  high in MUL or DIV state.
REQ-011 SHALL have port: STALL  output  1  pipeline hold request for IF/ID/EX.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL, in IDLE with START=1 and FLUSH=0, latch FUNC3 and operands, then go to MUL (FUNC3[2]=0) or DIV (FUNC3[2]=1); START SHALL be ignored in all other states.
REQ-014 SHALL drive STALL = (IDLE and START and not FLUSH) or MUL or DIV; STALL SHALL be 0 in DONE so the pipeline advances with RESULT.
REQ-015 SHALL run an iterative radix-2 shift-add multiplier with a 64-bit product and a 5-bit iteration counter: 32 cycles in MUL, then DONE; START sampled at edge k gives DONE=1 in cycle k+33.
REQ-016 SHALL return product bits [31:0] for MUL and [63:32] for MULH (signed x signed), MULHSU (signed x unsigned) and MULHU (unsigned x unsigned).
REQ-017 SHALL run a restoring divider on operand magnitudes: 32 cycles in DIV, then DONE at k+33; quotient truncates toward zero, remainder sign follows the dividend.
REQ-018 SHALL, for divisor 0, skip DIV and enter DONE at k+1: DIV/DIVU give 0xFFFFFFFF, REM/REMU give the dividend.
REQ-019 SHALL, for DIV/REM with 0x80000000 / 0xFFFFFFFF, skip DIV and enter DONE at k+1: DIV gives 0x80000000, REM gives 0.
REQ-020 SHALL go from DONE to IDLE unconditionally after one cycle; DONE SHALL be 1 only in the DONE state.
REQ-021 SHALL, on FLUSH=1 in any state, enter IDLE at the next edge with no DONE pulse and RESULT held; FLUSH SHALL win over a simultaneous START.
REQ-022 SHALL hold RESULT stable from the DONE cycle until the next DONE.

Reset
REQ-023 SHALL, on RESET=1 at a clock edge, force state IDLE, RESULT=0, DONE=0, BUSY=0, and clear the counter, product and remainder registers; RESET SHALL override START and FLUSH.
REQ-024 SHALL, on reset mid-operation, abandon the operation with no DONE pulse; STALL SHALL be 0 in the cycle after reset while START=0.

Configuration
REQ-025 SHALL compile a single-cycle multiplier when macro MULDIV_FAST_MUL_EN is defined: MUL state lasts 1 cycle (registered 64-bit combinational product) and DONE comes at k+2.
REQ-026 SHALL use the 32-cycle iterative multiplier of REQ-015 when MULDIV_FAST_MUL_EN is undefined; divide behaviour SHALL be the same either way.

Verification
REQ-027 SHALL cover MUL 7 x 0xFFFFFFFD -> RESULT 0xFFFFFFEB, DONE at k+33 (k+2 with MULDIV_FAST_MUL_EN), STALL high k..k+32.
REQ-028 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-029 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, each with DONE at k+33.
REQ-030 SHALL cover DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each with DONE at k+1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-031 SHALL cover FLUSH in the 10th DIV cycle -> IDLE next edge, no DONE, RESULT unchanged; START in the next IDLE cycle is accepted normally.
REQ-032 SHALL cover RESET in the 5th MUL cycle -> RESULT=0, DONE=0, BUSY=0 next cycle; START during DONE is ignored.
